// File: rtl/adder_pkg.sv
// adder_pkg
// Shared definitions for the multi-word add sequencer:
//   SLICE_W - width of one adder slice (the shared 8-bit adder)
//   state_t - sequencer states IDLE / RUN / DONE
//   clog2   - ceiling log2 that never returns less than 1, for counter widths
package adder_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to count 0..n-1; a single slice still gets a 1-bit counter.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// multiword_add_sequencer_if
// Request/response bundle of the multi-word add sequencer.
//   request : in_valid, in_ready, a, b, cin
//   response: out_valid, out_ready, sum, cout, ovf
// master = requester/consumer side, slave = the sequencer.
interface multiword_add_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/conditional_sum_adder.sv
// conditional_sum_adder
// Purely combinational 8-bit conditional-sum adder slice.
//   x, y : 8-bit operands
//   cin  : carry in
//   s    : 8-bit sum
//   cout : carry out
// The upper nibble is added for both possible carries in parallel with the
// lower nibble; the lower nibble's carry then selects the right upper result.
module conditional_sum_adder (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [4:0] lo;
  logic [4:0] hi_c0;
  logic [4:0] hi_c1;

  assign lo    = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'd0, cin};
  assign hi_c0 = {1'b0, x[7:4]} + {1'b0, y[7:4]};
  assign hi_c1 = {1'b0, x[7:4]} + {1'b0, y[7:4]} + 5'd1;

  assign s[3:0] = lo[3:0];
  assign s[7:4] = lo[4] ? hi_c1[3:0] : hi_c0[3:0];
  assign cout   = lo[4] ? hi_c1[4]   : hi_c0[4];

endmodule

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
// Adds two WIDTH-bit operands through one shared 8-bit adder slice, one
// slice per clock, least-significant slice first, rippling the carry through
// a register between slices.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of multiword_add_sequencer_if
//              request  in_valid/in_ready with a, b, cin
//              response out_valid/out_ready with sum, cout, ovf
// Latency is NSLICE cycles from acceptance; result is held until taken.
module multiword_add_sequencer
  import adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  multiword_add_sequencer_if.slave      bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = clog2(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_width_check
    $error("multiword_add_sequencer: WIDTH must be a positive multiple of 8");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;

  // Result copies loaded on the last RUN edge so the presented outputs stay
  // put even after a new request overwrites the working registers.
  logic [WIDTH-1:0] res_sum_q;
  logic             res_cout_q;
  logic             a_sign_q;
  logic             b_sign_q;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic [WIDTH-1:0]   sum_merged;

  assign slice_a = a_q[SLICE_W*idx +: SLICE_W];
  assign slice_b = b_q[SLICE_W*idx +: SLICE_W];

  conditional_sum_adder u_adder (
    .x    (slice_a),
    .y    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Working sum with the current slice dropped into place.
  always_comb begin
    sum_merged = sum_q;
    sum_merged[SLICE_W*idx +: SLICE_W] = slice_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      sum_q      <= '0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
      a_sign_q   <= 1'b0;
      b_sign_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_merged;
          carry_q <= slice_cout;
          if (idx == LAST_IDX) begin
            // idx parks on the last slice rather than wrapping.
            res_sum_q  <= sum_merged;
            res_cout_q <= slice_cout;
            a_sign_q   <= a_q[WIDTH-1];
            b_sign_q   <= b_q[WIDTH-1];
            state      <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is masked by rst so nothing can be offered during reset.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = res_sum_q;
  assign bus.cout      = res_cout_q;
  // Overflow: operands share a sign and the result sign differs from it.
  assign bus.ovf       = (a_sign_q ~^ b_sign_q) & (res_sum_q[WIDTH-1] ^ a_sign_q);

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

  localparam int W = 32;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   total_checks;
  int   passed_checks;

  multiword_add_sequencer_if #(.WIDTH(W)) bus ();

  multiword_add_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Offer one request, measure latency, check the result, then take it.
  task automatic do_txn(input vec_t v);
    int n;
    int lat;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({v.name, " ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.cin      = v.cin;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'd4);
    check({v.name, " sum"}, bus.sum, v.exp_sum);
    check({v.name, " cout/ovf"}, {30'd0, bus.cout, bus.ovf}, {30'd0, v.exp_cout, v.exp_ovf});
    $display("txn %s: a=%08h b=%08h cin=%0d -> sum=%08h cout=%0d ovf=%0d",
             v.name, v.a, v.b, v.cin, bus.sum, bus.cout, bus.ovf);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({v.name, " handoff"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  vec_t vecs[7];
  vec_t v;

  initial begin
    total_checks  = 0;
    passed_checks = 0;

    vecs[0] = '{"ripple",    32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{"sovf",      32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{"cin_slice", 32'h00FF00FF, 32'h0000FF00, 1'b1, 32'h01000000, 1'b0, 1'b0};
    vecs[3] = '{"zero",      32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[4] = '{"neg_ovf",   32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{"all_ones",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[6] = '{"mixed",     32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;

    // Reset state while rst is high.
    #3;
    check("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst outputs", {bus.sum[30:0], bus.cout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("release in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("release out_valid", {31'd0, bus.out_valid}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i]);
    end

    // Back-pressure: result held, new request refused while in DONE.
    bus.in_valid = 1'b1;
    bus.a = 32'hFFFFFFFF;
    bus.b = 32'h00000001;
    bus.cin = 1'b0;
    @(negedge clk);
    bus.a = 32'h12345678;
    bus.b = 32'h00000001;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp hold sum", bus.sum, 32'h00000000);
      check("bp hold flags", {29'd0, bus.cout, bus.ovf, bus.in_ready}, 32'b100);
      $display("txn bp cycle %0d: sum=%08h in_ready=%0d", i, bus.sum, bus.in_ready);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp release", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    v = '{"bp_new", 32'h12345678, 32'h00000001, 1'b0, 32'h12345679, 1'b0, 1'b0};
    do_txn(v);

    // Reset mid-operation after E2 with a nonzero held result.
    bus.in_valid = 1'b1;
    bus.a = 32'h00000010;
    bus.b = 32'h00000020;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst sum", bus.sum, 32'h00000000);
    check("midrst in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst no result", {31'd0, bus.out_valid}, 32'd0);
    v = '{"after_rst", 32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0};
    do_txn(v);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
